// File: rtl/maxpool_l1_if.sv
// Start/done handshake and shared layer-0/layer-1 memory bus used by the max-pooling stage.
interface maxpool_l1_if #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_W     = 12
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  crd;
    logic [ADDR_W-1:0]     caddr_rd;
    logic [DATA_WIDTH-1:0] cdata_rd;
    logic                  cwr;
    logic [ADDR_W-1:0]     caddr_wr;
    logic [DATA_WIDTH-1:0] cdata_wr;
    logic [2:0]            csel;

    modport master (
        input  start, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output start, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/maxpool_l1.sv
// 2x2 non-overlapping max pooling: reads each layer-0 window, writes its signed maximum
// to layer-1, one output word every six cycles.
module maxpool_l1 #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_W     = 12,
    parameter int IMG_W      = 64
) (
    input  logic          clk,
    input  logic          reset,
    maxpool_l1_if.master  bus
);
    localparam int LOG_W  = $clog2(IMG_W);
    localparam int HALF_W = LOG_W - 1;

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, WR, FIN} state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [HALF_W-1:0]             oy;
    logic [HALF_W-1:0]             ox;
    logic signed [DATA_WIDTH-1:0]  max_reg;
    logic [ADDR_W-1:0]             rd_addr_hold;
    logic [ADDR_W-1:0]             wr_addr_hold;
    logic [DATA_WIDTH-1:0]         wr_data_hold;
    logic [1:0]                    pix;
    logic [ADDR_W-1:0]             rd_addr;
    logic [ADDR_W-1:0]             wr_addr;
    logic                          last_window;
    logic                          reading;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RD0;
            RD0:     state_nxt = RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = RD3;
            RD3:     state_nxt = CAP;
            CAP:     state_nxt = WR;
            WR:      state_nxt = last_window ? FIN : RD0;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window pixel k sits at row 2*oy + k[1], column 2*ox + k[0].
    always_comb begin
        pix = 2'd0;
        case (state)
            RD1:     pix = 2'd1;
            RD2:     pix = 2'd2;
            RD3:     pix = 2'd3;
            default: pix = 2'd0;
        endcase
    end

    assign reading     = (state == RD0) || (state == RD1) || (state == RD2) || (state == RD3);
    assign rd_addr     = ADDR_W'({oy, pix[1], ox, pix[0]});
    assign wr_addr     = ADDR_W'({oy, ox});
    assign last_window = (&oy) && (&ox);

    // Read data trails each strobe by one cycle, so RD1..CAP capture pixels p0..p3.
    always_ff @(posedge clk) begin
        if (reset) begin
            oy           <= '0;
            ox           <= '0;
            max_reg      <= '0;
            rd_addr_hold <= '0;
            wr_addr_hold <= '0;
            wr_data_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        oy <= '0;
                        ox <= '0;
                    end
                end
                RD1: max_reg <= bus.cdata_rd;
                RD2, RD3, CAP: begin
                    if ($signed(bus.cdata_rd) > max_reg) max_reg <= bus.cdata_rd;
                end
                WR: begin
                    ox <= ox + 1'b1;
                    if (&ox) oy <= oy + 1'b1;
                end
                default: ;
            endcase
            if (reading)      rd_addr_hold <= rd_addr;
            if (state == WR) begin
                wr_addr_hold <= wr_addr;
                wr_data_hold <= max_reg;
            end
        end
    end

    // Addresses and write data fall back to their held copies whenever the strobe is low.
    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.crd      = 1'b0;
        bus.cwr      = 1'b0;
        bus.csel     = 3'b000;
        bus.caddr_rd = rd_addr_hold;
        bus.caddr_wr = wr_addr_hold;
        bus.cdata_wr = wr_data_hold;
        case (state)
            RD0, RD1, RD2, RD3: begin
                bus.busy     = 1'b1;
                bus.crd      = 1'b1;
                bus.csel     = 3'b001;
                bus.caddr_rd = rd_addr;
            end
            CAP: bus.busy = 1'b1;
            WR: begin
                bus.busy     = 1'b1;
                bus.cwr      = 1'b1;
                bus.csel     = 3'b011;
                bus.caddr_wr = wr_addr;
                bus.cdata_wr = max_reg;
            end
            FIN:     bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_maxpool_l1.sv
// Bench for maxpool_l1: layer-0 memory model, a window-max model predicting every output
// cycle, and directed passes with hand-computed results.
module tb_maxpool_l1;
    localparam int DW       = 20;
    localparam int AW       = 12;
    localparam int IW       = 64;
    localparam int OW       = 32;
    localparam int NOUT     = OW * OW;
    localparam int PASS_CYC = NOUT * 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    maxpool_l1_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    maxpool_l1 #(.DATA_WIDTH(DW), .ADDR_W(AW), .IMG_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem0   [IW*IW];
    logic [DW-1:0] l1_mem [NOUT];
    int            wcount [NOUT];
    int            pass_writes = 0;
    int            pass_dones  = 0;
    int            total       = 0;
    int            bad         = 0;
    logic          s_start     = 1'b0;
    logic          s_reset     = 1'b1;
    logic          pend_valid  = 1'b0;
    logic [AW-1:0] pend_addr   = '0;
    logic [50:0]   act;

    assign act = {bus.busy, bus.done, bus.crd, bus.cwr, bus.csel,
                  bus.caddr_rd, bus.caddr_wr, bus.cdata_wr};

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Signed maximum of 2x2 window number o, straight from layer-0 contents.
    function automatic logic [DW-1:0] win_max(input int o);
        int oyi, oxi;
        logic signed [DW-1:0] m, v;
        oyi = o / OW;
        oxi = o % OW;
        m = mem0[(2 * oyi) * IW + 2 * oxi];
        for (int k = 1; k < 4; k++) begin
            v = mem0[(2 * oyi + k / 2) * IW + 2 * oxi + k % 2];
            if (v > m) m = v;
        end
        return m;
    endfunction

    always @(posedge clk) begin
        s_start = bus.start;
        s_reset = reset;
    end

    // Layer-0 memory: data for a read strobe is presented throughout the following cycle.
    always @(negedge clk) begin
        bus.cdata_rd = pend_valid ? mem0[pend_addr] : '0;
        pend_valid   = (bus.crd === 1'b1);
        pend_addr    = bus.caddr_rd;
    end

    // Cycle-accurate expectation from the pass cycle number, compared every cycle.
    always @(negedge clk) begin : model_check
        int            cyc;
        int            o, ph, oyi, oxi;
        logic          busy_e, done_e, crd_e, cwr_e;
        logic [2:0]    csel_e;
        logic [AW-1:0] last_ra, last_wa;
        logic [DW-1:0] last_wd;
        logic [50:0]   exp_v;

        if (s_reset) begin
            cyc = 0; last_ra = '0; last_wa = '0; last_wd = '0;
        end else if (cyc == 0) begin
            if (s_start) begin
                cyc = 1;
                for (int i = 0; i < NOUT; i++) wcount[i] = 0;
                pass_writes = 0;
                pass_dones  = 0;
            end
        end else if (cyc == PASS_CYC + 1) begin
            cyc = 0;
        end else begin
            cyc++;
        end

        busy_e = (cyc >= 1) && (cyc <= PASS_CYC);
        done_e = (cyc == PASS_CYC + 1);
        crd_e  = 1'b0;
        cwr_e  = 1'b0;
        csel_e = 3'b000;
        if (busy_e) begin
            o   = (cyc - 1) / 6;
            ph  = (cyc - 1) % 6;
            oyi = o / OW;
            oxi = o % OW;
            if (ph < 4) begin
                crd_e   = 1'b1;
                csel_e  = 3'b001;
                last_ra = AW'((2 * oyi + ph / 2) * IW + 2 * oxi + ph % 2);
            end else if (ph == 5) begin
                cwr_e   = 1'b1;
                csel_e  = 3'b011;
                last_wa = AW'(o);
                last_wd = win_max(o);
            end
        end
        exp_v = {busy_e, done_e, crd_e, cwr_e, csel_e, last_ra, last_wa, last_wd};
        checkOutput("cycle_outputs", 64'(act), 64'(exp_v));

        if (bus.cwr === 1'b1) begin
            pass_writes++;
            wcount[bus.caddr_wr[9:0]]++;
            l1_mem[bus.caddr_wr[9:0]] = bus.cdata_wr;
        end
        if (bus.done === 1'b1) pass_dones++;
    end

    task automatic applyStimulus(input int restart_at, input int reset_at, output int done_at);
        int w_snap;
        done_at = 0;
        w_snap  = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= PASS_CYC + 150 && done_at == 0; i++) begin
            if (bus.done === 1'b1) done_at = i;
            if (reset_at > 0 && i == reset_at + 1)
                checkOutput("reset_abort_outputs", 64'(act), 64'(0));
            if (reset_at > 0 && i == reset_at + 2) w_snap = pass_writes;
            bus.start = (i == restart_at);
            reset     = (i == reset_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        if (reset_at > 0) begin
            checkOutput("reset_no_done", 64'(done_at), 64'(0));
            checkOutput("reset_dones", 64'(pass_dones), 64'(0));
            checkOutput("reset_writes_frozen", 64'(pass_writes), 64'(w_snap));
            checkOutput("reset_write_count", 64'(pass_writes), 64'(500));
        end
    endtask

    task automatic checkFullPass(input int done_at);
        int nbad;
        nbad = 0;
        for (int i = 0; i < NOUT; i++) if (wcount[i] != 1) nbad++;
        checkOutput("done_cycle", 64'(done_at), 64'(PASS_CYC + 1));
        checkOutput("write_count", 64'(pass_writes), 64'(NOUT));
        checkOutput("done_count", 64'(pass_dones), 64'(1));
        checkOutput("addr_written_once", 64'(nbad), 64'(0));
    endtask

    task automatic fillRandom();
        for (int a = 0; a < IW * IW; a++) mem0[a] = DW'($urandom);
    endtask

    initial begin
        int done_at;
        bus.start = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 64'(act), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] ramp pass with a stray start at cycle 100");
        for (int a = 0; a < IW * IW; a++) mem0[a] = DW'(a << 16);
        applyStimulus(100, 0, done_at);
        checkFullPass(done_at);
        checkOutput("ramp_l1_0", 64'(l1_mem[0]), 64'(20'h10000));
        checkOutput("ramp_l1_1", 64'(l1_mem[1]), 64'(20'h30000));
        checkOutput("ramp_l1_4", 64'(l1_mem[4]), 64'(20'h90000));
        checkOutput("ramp_l1_32", 64'(l1_mem[32]), 64'(20'h10000));

        $display("[TB] signed maximum and maximum in each window slot");
        fillRandom();
        mem0[0]  = 20'hF0000;
        mem0[1]  = 20'hF8000;
        mem0[64] = 20'hE0000;
        mem0[65] = 20'hFC000;
        for (int o = 1; o <= 4; o++) begin
            for (int k = 0; k < 4; k++)
                mem0[(k / 2) * IW + 2 * o + k % 2] = (k == o - 1) ? 20'h12345 : 20'h00001;
        end
        applyStimulus(0, 0, done_at);
        checkFullPass(done_at);
        checkOutput("signed_max", 64'(l1_mem[0]), 64'(20'hFC000));
        for (int o = 1; o <= 4; o++)
            checkOutput($sformatf("max_slot_p%0d", o - 1), 64'(l1_mem[o]), 64'(20'h12345));

        $display("[TB] reset at cycle 3000 of a pass");
        fillRandom();
        applyStimulus(0, 3000, done_at);

        $display("[TB] full random pass after the aborted one");
        fillRandom();
        applyStimulus(0, 0, done_at);
        checkFullPass(done_at);
        checkOutput("random_l1_last", 64'(l1_mem[NOUT-1]), 64'(win_max(NOUT - 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
